// File: rtl/aes128_iter_core_if.sv
// Host-side bundle for the iterative AES-128 core: key load, block in, result out.
interface aes128_iter_core_if;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         key_ok;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_mode;

    modport master (
        output key_valid, key_in, in_valid, in_mode, in_data, out_ready,
        input  key_ready, key_ok, in_ready, out_valid, out_data, out_mode
    );

    modport slave (
        input  key_valid, key_in, in_valid, in_mode, in_data, out_ready,
        output key_ready, key_ok, in_ready, out_valid, out_data, out_mode
    );
endinterface

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 enc/dec, one block in flight; result valid 10/RPC cycles after accept.
// Key expansion takes 10 cycles; result is held in DONE until out_ready, nothing accepted meanwhile.
module aes128_iter_core #(
    parameter int RPC = 1
) (
    input logic              clk,
    input logic              rst_n,
    aes128_iter_core_if.slave bus
);
    if (!(RPC == 1 || RPC == 2 || RPC == 5 || RPC == 10)) begin : g_bad_rpc
        $error("aes128_iter_core: RPC must be 1, 2, 5 or 10");
    end

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [0:2047] ISBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] isbox(input logic [7:0] x);
        return ISBOX[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k of a block sits at [127-8k -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(r + 4*c) -: 8] = sbox(s[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(r + 4*c) -: 8] = isbox(s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix_all(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127 - 32*c -: 32];
            o[127 - 32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                   xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_all(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   m9 [4], m11 [4], m13 [4], m14 [4];
        logic [7:0]   x2, x4, x8;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                a[i]   = s[127 - 32*c - 8*i -: 8];
                x2     = xt(a[i]);
                x4     = xt(x2);
                x8     = xt(x4);
                m9[i]  = x8 ^ a[i];
                m11[i] = x8 ^ x2 ^ a[i];
                m13[i] = x8 ^ x4 ^ a[i];
                m14[i] = x8 ^ x4 ^ x2;
            end
            o[127 - 32*c -: 32] = {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                                   m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                                   m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                                   m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
        end
        return o;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] p, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(p[23:16]), sbox(p[15:8]), sbox(p[7:0]), sbox(p[31:24])} ^ {rc, 24'h0};
        n0 = p[127:96] ^ t;
        n1 = p[95:64] ^ n0;
        n2 = p[63:32] ^ n1;
        n3 = p[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    typedef enum logic [2:0] {IDLE, KEYEXP, READY, RUN, DONE} state_t;

    state_t       state;
    logic         key_ready_q, key_ok_q, rdy_q, out_valid_q, out_mode_q, mode_q;
    logic [127:0] out_data_q, st;
    logic [127:0] rk [0:10];
    logic [3:0]   kcnt, rcnt;
    logic [7:0]   rcon;
    logic [127:0] chain [0:RPC];
    logic         in_ready, key_hs, in_hs;

    // A pending key always beats a pending block in READY.
    assign in_ready = rdy_q && !bus.key_valid;
    assign key_hs   = bus.key_valid && key_ready_q;
    assign in_hs    = bus.in_valid && in_ready;

    assign bus.key_ready = key_ready_q;
    assign bus.key_ok    = key_ok_q;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_mode  = out_mode_q;

    assign chain[0] = st;
    for (genvar j = 0; j < RPC; j++) begin : g_round
        logic [3:0]   rnd;
        logic [127:0] enc_t, dec_t;
        assign rnd   = rcnt + 4'(j);
        assign enc_t = (rnd == 4'd10) ? sub_shift(chain[j]) ^ rk[rnd]
                                      : mix_all(sub_shift(chain[j])) ^ rk[rnd];
        assign dec_t = inv_sub_shift(chain[j]) ^ rk[4'd10 - rnd];
        assign chain[j+1] = !mode_q ? enc_t : (rnd == 4'd10) ? dec_t : inv_mix_all(dec_t);
    end

    always_ff @(posedge clk) begin
        if (key_hs)
            rk[0] <= bus.key_in;
        else if (state == KEYEXP)
            rk[kcnt] <= key_step(rk[kcnt - 4'd1], rcon);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            key_ready_q <= 1'b1;
            key_ok_q    <= 1'b0;
            rdy_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mode_q  <= 1'b0;
            mode_q      <= 1'b0;
            st          <= '0;
            kcnt        <= 4'd1;
            rcnt        <= 4'd1;
            rcon        <= 8'h01;
        end else begin
            case (state)
                IDLE: if (key_hs) begin
                    state       <= KEYEXP;
                    kcnt        <= 4'd1;
                    rcon        <= 8'h01;
                    key_ready_q <= 1'b0;
                    key_ok_q    <= 1'b0;
                end
                KEYEXP: begin
                    kcnt <= kcnt + 4'd1;
                    rcon <= xt(rcon);
                    if (kcnt == 4'd10) begin
                        state       <= READY;
                        key_ok_q    <= 1'b1;
                        key_ready_q <= 1'b1;
                        rdy_q       <= 1'b1;
                    end
                end
                READY: if (key_hs) begin
                    state       <= KEYEXP;
                    kcnt        <= 4'd1;
                    rcon        <= 8'h01;
                    key_ready_q <= 1'b0;
                    key_ok_q    <= 1'b0;
                    rdy_q       <= 1'b0;
                end else if (in_hs) begin
                    state       <= RUN;
                    st          <= bus.in_data ^ (bus.in_mode ? rk[10] : rk[0]);
                    mode_q      <= bus.in_mode;
                    rcnt        <= 4'd1;
                    key_ready_q <= 1'b0;
                    rdy_q       <= 1'b0;
                end
                RUN: begin
                    st   <= chain[RPC];
                    rcnt <= rcnt + 4'(RPC);
                    if (rcnt == 4'(11 - RPC)) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= chain[RPC];
                        out_mode_q  <= mode_q;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state       <= READY;
                    out_valid_q <= 1'b0;
                    key_ready_q <= 1'b1;
                    rdy_q       <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
